// File: rtl/apb_i2c_regif.sv
// apb_i2c_regif: APB3 slave register front-end for i2c_bridge.
// Holds the bridge configuration (i2c_con1, i2c_con2, Din), returns status and
// captured receive data, inserts WAIT_STATES wait cycles per transfer, clears
// the enable bit once the bridge reports busy and snapshots Dout when a
// transfer completes.
// Optional feature macro: APB_I2C_IRQ_EN (transfer-done flag, mask register at
// word address 5 and the irq output). Without it irq is 0 and address 5 errors.
module apb_i2c_regif #(
    parameter int ADDR_W      = 5,
    parameter int WAIT_STATES = 1,
    parameter int BUSY_BIT    = 7
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [ADDR_W-1:0] PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              PSLVERR,
    output logic [7:0]        i2c_con1,
    output logic [7:0]        i2c_con2,
    output logic [31:0]       Din,
    input  logic [31:0]       Dout,
    input  logic [7:0]        i2c_stat,
    output logic              irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] WAIT_LOAD  = 3'(WAIT_STATES);
    localparam logic [2:0] SEL_CON1   = 3'd0;
    localparam logic [2:0] SEL_CON2   = 3'd1;
    localparam logic [2:0] SEL_TXDATA = 3'd2;
    localparam logic [2:0] SEL_RXDATA = 3'd3;
    localparam logic [2:0] SEL_STAT   = 3'd4;
`ifdef APB_I2C_IRQ_EN
    localparam logic [2:0] SEL_IRQ    = 3'd5;
`endif

    state_t      state_r;
    logic [2:0]  cnt_r;
    logic [31:0] prdata_r;
    logic        pready_r;
    logic        pslverr_r;
    logic [7:0]  con1_r;
    logic [7:0]  con2_r;
    logic [31:0] din_r;
    logic [31:0] rx_hold_r;
    logic        prev_busy_r;

    logic [2:0]  sel_s;
    logic        busy_s;
    logic        fall_s;
    logic        commit_s;
    logic [31:0] rd_data_s;
    logic        acc_err_s;
    logic [31:0] resp_data_s;
    logic        addr_unused_s;

`ifdef APB_I2C_IRQ_EN
    logic        done_flag_r;
    logic        irq_mask_r;
    logic        irq_r;
    logic        irq_wr_s;
    logic        done_next_s;
    logic        mask_next_s;
`endif

    // Byte-lane bits of the address carry no meaning for word registers.
    assign addr_unused_s = ^PADDR[1:0];
    assign sel_s         = PADDR[4:2];
    assign busy_s        = i2c_stat[BUSY_BIT];
    assign fall_s        = prev_busy_r & ~busy_s;
    // A write commits only in the response cycle and only if it was accepted.
    assign commit_s      = (state_r == ST_RESP) & PSEL & PENABLE & PWRITE & ~pslverr_r;

    // Decode the addressed register: read value and whether the access errors.
    always_comb begin
        rd_data_s = 32'd0;
        acc_err_s = 1'b0;
        case (sel_s)
            SEL_CON1: begin
                rd_data_s = {24'd0, con1_r};
                acc_err_s = PWRITE & busy_s;
            end
            SEL_CON2: begin
                rd_data_s = {24'd0, con2_r};
                acc_err_s = PWRITE & busy_s;
            end
            SEL_TXDATA: begin
                rd_data_s = din_r;
                acc_err_s = PWRITE & busy_s;
            end
            SEL_RXDATA: begin
                rd_data_s = rx_hold_r;
                acc_err_s = PWRITE;
            end
            SEL_STAT: begin
                rd_data_s = {24'd0, i2c_stat};
                acc_err_s = PWRITE;
            end
`ifdef APB_I2C_IRQ_EN
            SEL_IRQ: begin
                rd_data_s = {30'd0, irq_mask_r, done_flag_r};
                acc_err_s = 1'b0;
            end
`endif
            default: begin
                rd_data_s = 32'd0;
                acc_err_s = 1'b1;
            end
        endcase
        if (acc_err_s || PWRITE) begin
            resp_data_s = 32'd0;
        end else begin
            resp_data_s = rd_data_s;
        end
    end

    // APB handshake FSM; response outputs are loaded on the edge entering RESP
    // so PREADY/PRDATA/PSLVERR come straight from flops.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 3'd0;
            pready_r  <= 1'b0;
            pslverr_r <= 1'b0;
            prdata_r  <= 32'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                    prdata_r  <= 32'd0;
                    if (PSEL && !PENABLE) begin
                        if (WAIT_LOAD == 3'd0) begin
                            state_r   <= ST_RESP;
                            pready_r  <= 1'b1;
                            pslverr_r <= acc_err_s;
                            prdata_r  <= resp_data_s;
                        end else begin
                            state_r <= ST_WAIT;
                            cnt_r   <= WAIT_LOAD;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!PSEL) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 3'd0;
                    end else if (PENABLE) begin
                        if (cnt_r <= 3'd1) begin
                            state_r   <= ST_RESP;
                            cnt_r     <= 3'd0;
                            pready_r  <= 1'b1;
                            pslverr_r <= acc_err_s;
                            prdata_r  <= resp_data_s;
                        end else begin
                            cnt_r <= cnt_r - 3'd1;
                        end
                    end
                end
                ST_RESP: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 3'd0;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                    prdata_r  <= 32'd0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 3'd0;
                    pready_r  <= 1'b0;
                    pslverr_r <= 1'b0;
                    prdata_r  <= 32'd0;
                end
            endcase
        end
    end

    // CON1: an APB write beats the enable self-clear that busy would cause.
    always_ff @(posedge CLK) begin
        if (RST) begin
            con1_r <= 8'd0;
        end else if (commit_s && (sel_s == SEL_CON1)) begin
            con1_r <= PWDATA[7:0];
        end else if (busy_s) begin
            con1_r[1] <= 1'b0;
        end
    end

    // CON2 and TXDATA: plain writable configuration.
    always_ff @(posedge CLK) begin
        if (RST) begin
            con2_r <= 8'd0;
            din_r  <= 32'd0;
        end else begin
            if (commit_s && (sel_s == SEL_CON2)) begin
                con2_r <= PWDATA[7:0];
            end
            if (commit_s && (sel_s == SEL_TXDATA)) begin
                din_r <= PWDATA;
            end
        end
    end

    // Track busy and capture Dout when a bridge transfer finishes.
    always_ff @(posedge CLK) begin
        if (RST) begin
            prev_busy_r <= 1'b0;
            rx_hold_r   <= 32'd0;
        end else begin
            prev_busy_r <= busy_s;
            if (fall_s) begin
                rx_hold_r <= Dout;
            end
        end
    end

`ifdef APB_I2C_IRQ_EN
    assign irq_wr_s = commit_s & (sel_s == SEL_IRQ);

    // Next done flag (set beats write-1-clear) and next mask.
    always_comb begin
        done_next_s = done_flag_r;
        mask_next_s = irq_mask_r;
        if (fall_s) begin
            done_next_s = 1'b1;
        end else if (irq_wr_s && PWDATA[0]) begin
            done_next_s = 1'b0;
        end else begin
            done_next_s = done_flag_r;
        end
        if (irq_wr_s) begin
            mask_next_s = PWDATA[1];
        end else begin
            mask_next_s = irq_mask_r;
        end
    end

    // Done flag, mask and the registered interrupt line.
    always_ff @(posedge CLK) begin
        if (RST) begin
            done_flag_r <= 1'b0;
            irq_mask_r  <= 1'b0;
            irq_r       <= 1'b0;
        end else begin
            done_flag_r <= done_next_s;
            irq_mask_r  <= mask_next_s;
            irq_r       <= done_next_s & mask_next_s;
        end
    end

    assign irq = irq_r;
`else
    assign irq = 1'b0;
`endif

    assign PRDATA   = prdata_r;
    assign PREADY   = pready_r;
    assign PSLVERR  = pslverr_r;
    assign i2c_con1 = con1_r;
    assign i2c_con2 = con2_r;
    assign Din      = din_r;

endmodule

// File: tb/tb_apb_i2c_regif.sv
// tb_apb_i2c_regif: directed and randomized APB traffic against a
// transaction-level model of the register map and bridge status events.
module tb_apb_i2c_regif;

    localparam int WS = 1;
`ifdef APB_I2C_IRQ_EN
    localparam bit HAS_IRQ = 1'b1;
`else
    localparam bit HAS_IRQ = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [4:0]  PADDR = 5'd0;
    logic [31:0] PWDATA = 32'd0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [7:0]  i2c_con1;
    logic [7:0]  i2c_con2;
    logic [31:0] Din;
    logic [31:0] Dout = 32'd0;
    logic [7:0]  i2c_stat = 8'h05;
    logic        irq;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [7:0]  m_con1 = 8'd0;
    logic [7:0]  m_con2 = 8'd0;
    logic [31:0] m_din = 32'd0;
    logic [31:0] m_rx = 32'd0;
    logic        m_done = 1'b0;
    logic        m_mask = 1'b0;
    logic [7:0]  m_stat = 8'h05;

    apb_i2c_regif #(.ADDR_W(5), .WAIT_STATES(WS), .BUSY_BIT(7)) dut (
        .CLK(CLK), .RST(RST), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY),
        .PSLVERR(PSLVERR), .i2c_con1(i2c_con1), .i2c_con2(i2c_con2), .Din(Din),
        .Dout(Dout), .i2c_stat(i2c_stat), .irq(irq)
    );

    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic model_err(input logic wr, input int sel);
        logic mapped;
        mapped = (sel <= 4) || (HAS_IRQ && sel == 5);
        return !mapped || (wr && (sel == 3 || sel == 4)) || (wr && sel <= 2 && m_stat[7]);
    endfunction

    function automatic logic [31:0] model_rd(input int sel);
        case (sel)
            0: return {24'd0, m_con1};
            1: return {24'd0, m_con2};
            2: return m_din;
            3: return m_rx;
            4: return {24'd0, m_stat};
            5: return {30'd0, m_mask, m_done};
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_wr(input int sel, input logic [31:0] d);
        case (sel)
            0: m_con1 = d[7:0];
            1: m_con2 = d[7:0];
            2: m_din = d;
            5: begin
                if (d[0]) m_done = 1'b0;
                m_mask = d[1];
            end
            default: ;
        endcase
    endtask

    task automatic check_outs(input string tag);
        check_val({tag, ".con1"}, {24'd0, i2c_con1}, {24'd0, m_con1});
        check_val({tag, ".con2"}, {24'd0, i2c_con2}, {24'd0, m_con2});
        check_val({tag, ".din"}, Din, m_din);
        check_val({tag, ".irq"}, {31'd0, irq}, {31'd0, HAS_IRQ & m_done & m_mask});
    endtask

    // One APB transfer; acc = number of ACCESS cycles up to and including PREADY.
    task automatic apb_xfer(input logic wr, input logic [4:0] addr, input logic [31:0] wdata,
                            output logic [31:0] rdata, output logic err, output int acc);
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(posedge CLK); #1;
        PENABLE = 1'b1;
        acc = 0; rdata = 32'd0; err = 1'b0;
        for (int i = 0; i < 16; i++) begin
            @(negedge CLK);
            acc = acc + 1;
            if (PREADY) begin
                rdata = PRDATA;
                err = PSLVERR;
                break;
            end
        end
        @(posedge CLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic do_op(input logic wr, input int sel, input logic [31:0] d, input string tag);
        logic [31:0] rd;
        logic        er;
        int          acc;
        logic        exp_err;
        logic [1:0]  lo;
        lo = 2'($urandom_range(0, 3));
        exp_err = model_err(wr, sel);
        apb_xfer(wr, {3'(sel), lo}, d, rd, er, acc);
        check_val({tag, ".ready_cycle"}, 32'(acc), 32'(WS + 1));
        check_val({tag, ".pslverr"}, {31'd0, er}, {31'd0, exp_err});
        if (!wr) check_val({tag, ".prdata"}, rd, exp_err ? 32'd0 : model_rd(sel));
        if (wr && !exp_err) model_wr(sel, d);
        check_outs(tag);
    endtask

    // Change bridge status/data and let exactly one edge see the new values.
    task automatic set_stat(input logic [7:0] s, input logic [31:0] d);
        @(posedge CLK); #1;
        i2c_stat = s; Dout = d;
        @(posedge CLK); #1;
        if (s[7]) m_con1[1] = 1'b0;
        if (!s[7] && m_stat[7]) begin
            m_rx = d;
            m_done = 1'b1;
        end
        m_stat = s;
    endtask

    // SETUP then drop PSEL during the wait phase: no response, no commit.
    task automatic apb_abort(input int sel, input logic [31:0] d);
        logic seen;
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = {3'(sel), 2'b00}; PWDATA = d;
        @(posedge CLK); #1;
        PSEL = 1'b0; PWRITE = 1'b0;
        seen = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (PREADY) seen = 1'b1;
        end
        check_val("abort.pready", {31'd0, seen}, 32'd0);
        check_outs("abort");
    endtask

    initial begin
        int op;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        @(negedge CLK);
        check_val("rst.prdata", PRDATA, 32'd0);
        check_val("rst.pready", {31'd0, PREADY}, 32'd0);
        check_val("rst.pslverr", {31'd0, PSLVERR}, 32'd0);
        check_outs("rst");

        do_op(1'b0, 4, 32'd0, "stat_rd");
        do_op(1'b1, 0, 32'h000000DF, "con1_wr");
        do_op(1'b1, 1, 32'h000000E5, "con2_wr");
        do_op(1'b1, 2, 32'h0000FEAB, "tx_wr");
        check_val("dir.con1", {24'd0, i2c_con1}, 32'h000000DF);
        check_val("dir.con2", {24'd0, i2c_con2}, 32'h000000E5);
        check_val("dir.din", Din, 32'h0000FEAB);

        set_stat(8'h80, 32'hCAFE0055);
        check_val("selfclr.con1", {24'd0, i2c_con1}, 32'h000000DD);
        do_op(1'b1, 2, 32'h00001234, "tx_busy");
        check_val("busy.din", Din, 32'h0000FEAB);

        set_stat(8'h00, 32'hCAFE0055);
        do_op(1'b0, 3, 32'd0, "rx_rd");
        set_stat(8'h00, 32'h12345678);
        do_op(1'b0, 3, 32'd0, "rx_hold");
        do_op(1'b0, 7, 32'd0, "unmapped_rd");
        apb_abort(1, 32'h0000005A);

        do_op(1'b1, 5, 32'h00000003, "irq_clr_mask");
        set_stat(8'h80, 32'h00000011);
        set_stat(8'h00, 32'h00000022);
        check_outs("irq_done");
        do_op(1'b1, 5, 32'h00000003, "irq_w1c");
        do_op(1'b0, 5, 32'd0, "irq_rd");

        for (int it = 0; it < 300; it++) begin
            op = $urandom_range(0, 9);
            if (op < 4) begin
                do_op(1'b1, $urandom_range(0, 7), $urandom, "rnd_wr");
            end else if (op < 8) begin
                do_op(1'b0, $urandom_range(0, 7), 32'd0, "rnd_rd");
            end else if (op == 8) begin
                set_stat(8'($urandom), $urandom);
                check_outs("rnd_stat");
            end else begin
                apb_abort($urandom_range(0, 2), $urandom);
            end
        end

        // Reset in the middle of a transfer
        set_stat(8'h00, 32'h0BADF00D);
        @(posedge CLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 5'h04; PWDATA = 32'h000000AA;
        @(posedge CLK); #1;
        PENABLE = 1'b1; RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        m_con1 = 8'd0; m_con2 = 8'd0; m_din = 32'd0; m_rx = 32'd0; m_done = 1'b0; m_mask = 1'b0;
        @(negedge CLK);
        check_val("midrst.pready", {31'd0, PREADY}, 32'd0);
        check_val("midrst.prdata", PRDATA, 32'd0);
        check_outs("midrst");
        do_op(1'b0, 3, 32'd0, "midrst.rx");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
